// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator-ALU command sequencer.
//   - ALU opcode constants (add .. nxor)
//   - response status codes returned on rsp_err
//   - sequencer state encoding
//   - opcode legality and status classification helpers
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MULT = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_SR   = 5'd5;
    localparam logic [4:0] OP_SL   = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_XOR  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_NAND = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12;
    localparam logic [4:0] OP_NXOR = 5'd13;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_DIV0 = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NXOR);
    endfunction

    // Overflow only means something for add/sub; the divide-by-zero flag is
    // reported for anything else that raises it.
    function automatic logic [1:0] classify_err(input logic [4:0] op,
                                                input logic       ovf,
                                                input logic       dbz);
        if (ovf && (op == OP_ADD || op == OP_SUB))
            return ERR_OVF;
        else if (dbz)
            return ERR_DIV0;
        else
            return ERR_OK;
    endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// Saturating up-counter used for the operation and error statistics.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset (clears q)
//   clear - synchronous clear, wins over inc
//   inc   - count one event; holds at all-ones
//   q     - current count
module alu_sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            inc,
    output logic [CNTW-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issuing-side controller for the 16-bit accumulator ALU. Accepts one
// operation per request handshake, screens out illegal opcodes and divide by
// zero, drives the ALU for a fixed latency, captures the accumulator and
// flags, and returns them on a response handshake. One operation in flight.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/ready/op/a/b   - host request channel
//   rsp_valid/ready/data/err - host response channel (err: 0 ok, 1 ovf,
//                              2 div-by-zero, 3 illegal opcode)
//   alu_cmd/a/b/rst/noop     - registered drive to the ALU
//   alu_acc/overflow/divbyzero - ALU results
//   op_count, err_count      - saturating statistics
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int N    = 16,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [N-1:0]    req_a,
    input  logic [N-1:0]    req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*N-1:0]  rsp_data,
    output logic [1:0]      rsp_err,
    output logic [4:0]      alu_cmd,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic            alu_rst,
    output logic            alu_noop,
    input  logic [2*N-1:0]  alu_acc,
    input  logic            alu_overflow,
    input  logic            alu_divbyzero,
    output logic [CNTW-1:0] op_count,
    output logic [CNTW-1:0] err_count
);

    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

    state_t         state, state_next;
    logic [4:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic [3:0]     lat_cnt;
    logic           req_fire, rsp_fire;
    logic           reject_ill, reject_div0, lat_done;

    // Handshake readiness is decoded from the state register only, so the
    // request and response channels can never fire in the same cycle.
    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign req_fire    = req_valid && req_ready;
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign reject_ill  = !op_legal(req_op);
    assign reject_div0 = (req_op == OP_DIV) && (req_b == '0);
    assign lat_done    = (lat_cnt == 4'd0);

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: state_next = ST_IDLE;
            ST_IDLE:  if (req_fire)
                          state_next = (reject_ill || reject_div0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (lat_done) state_next = ST_RESP;
            ST_RESP:  if (rsp_fire) state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_CLEAR;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            lat_cnt  <= '0;
            rsp_data <= '0;
            rsp_err  <= ERR_OK;
            alu_cmd  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_rst  <= 1'b1;
            alu_noop <= 1'b1;
        end else begin
            state <= state_next;
            case (state)
                ST_CLEAR: alu_rst <= 1'b0;
                ST_IDLE: begin
                    if (req_fire) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        // Rejected requests go straight to RESP, so their
                        // status is settled here and the ALU stays idle.
                        if (reject_ill) begin
                            rsp_err  <= ERR_ILL;
                            rsp_data <= '0;
                        end else if (reject_div0) begin
                            rsp_err  <= ERR_DIV0;
                            rsp_data <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_cmd  <= op_q;
                    alu_a    <= a_q;
                    alu_b    <= b_q;
                    alu_noop <= 1'b0;
                    lat_cnt  <= LAT_LOAD;
                end
                ST_WAIT: begin
                    if (lat_done) begin
                        rsp_data <= alu_acc;
                        rsp_err  <= classify_err(op_q, alu_overflow, alu_divbyzero);
                        alu_noop <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    alu_sat_counter #(.CNTW(CNTW)) u_op_count (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_CLEAR),
        .inc   (rsp_fire),
        .q     (op_count)
    );

    alu_sat_counter #(.CNTW(CNTW)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_CLEAR),
        .inc   (rsp_fire && (rsp_err != ERR_OK)),
        .q     (err_count)
    );

endmodule
